// File: rtl/demux_pkg.sv
// Shared route encoding and FIFO sizing for the 1-to-3 stream demultiplexer.
package demux_pkg;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    // Indexed as {S1,S}; identical to the select encoding of the matching mux.
    localparam logic [1:0] ROUTE_A = 2'b11;
    localparam logic [1:0] ROUTE_B = 2'b10;
    localparam logic [1:0] ROUTE_D = 2'b0x;

    typedef enum logic [1:0] {
        RT_A = 2'd0,
        RT_B = 2'd1,
        RT_D = 2'd2
    } route_e;

    function automatic route_e route_of(input logic [1:0] sel);
        if (sel ==? ROUTE_D) begin
            return RT_D;
        end else if (sel == ROUTE_A) begin
            return RT_A;
        end
        return RT_B;
    endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry valid/ready FIFO; head is the registered entry at the read pointer.
module fifo2
    import demux_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid
);

    logic [W-1:0]     r_mem [DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign valid  = (r_count != CNT_W'(0));
    assign head   = r_mem[r_rptr];
    // Push is refused when full, so there is no pass-through at count 2.
    assign w_push = push & ~full;
    assign w_pop  = pop & valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/threedemux_stream.sv
// Routes one input stream to output A, B or D by {S1,S}, each through its own 2-deep FIFO.
module threedemux_stream
    import demux_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         S,
    input  logic         S1,
    output logic [W-1:0] a_data,
    output logic [W-1:0] b_data,
    output logic [W-1:0] d_data,
    output logic         a_valid,
    output logic         b_valid,
    output logic         d_valid,
    input  logic         a_ready,
    input  logic         b_ready,
    input  logic         d_ready,
    output logic         busy
);

    route_e w_route;
    logic   w_accept;
    logic   w_a_full;
    logic   w_b_full;
    logic   w_d_full;

    assign w_route = route_of({S1, S});

    // Ready follows the selected FIFO only; it never looks at in_valid.
    always_comb begin
        in_ready = 1'b0;
        unique case (w_route)
            RT_A:    in_ready = ~w_a_full;
            RT_B:    in_ready = ~w_b_full;
            default: in_ready = ~w_d_full;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign busy     = a_valid | b_valid | d_valid;

    fifo2 #(.W(W)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept & (w_route == RT_A)),
        .push_data (in_data),
        .full      (w_a_full),
        .pop       (a_ready),
        .head      (a_data),
        .valid     (a_valid)
    );

    fifo2 #(.W(W)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept & (w_route == RT_B)),
        .push_data (in_data),
        .full      (w_b_full),
        .pop       (b_ready),
        .head      (b_data),
        .valid     (b_valid)
    );

    fifo2 #(.W(W)) u_fifo_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_accept & (w_route == RT_D)),
        .push_data (in_data),
        .full      (w_d_full),
        .pop       (d_ready),
        .head      (d_data),
        .valid     (d_valid)
    );

endmodule

// File: tb/tb_threedemux_stream.sv
// Self-checking bench for threedemux_stream: directed scenarios plus a queue-based random scoreboard.
module tb_threedemux_stream;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       S;
    logic       S1;
    logic [1:0] a_data, b_data, d_data;
    logic       a_valid, b_valid, d_valid;
    logic       a_ready, b_ready, d_ready;
    logic       busy;

    int total;
    int bad;

    threedemux_stream #(.W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .S        (S),
        .S1       (S1),
        .a_data   (a_data),
        .b_data   (b_data),
        .d_data   (d_data),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .d_valid  (d_valid),
        .a_ready  (a_ready),
        .b_ready  (b_ready),
        .d_ready  (d_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] data, input logic s1, input logic s);
        in_data  = data;
        S1       = s1;
        S        = s;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 2'b00; S = 1'b0; S1 = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; d_ready = 1'b1;
        #2;
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || d_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valids got a=%b b=%b d=%b want 000", a_valid, b_valid, d_valid); end
        total++; if (a_data !== 2'b00 || b_data !== 2'b00 || d_data !== 2'b00) begin bad++;
            $display("FAIL reset_data got a=%b b=%b d=%b want 00", a_data, b_data, d_data); end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL reset_ready_busy got in_ready=%b busy=%b want 1 0", in_ready, busy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_routing();
        send(2'b01, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (a_valid !== 1'b1 || a_data !== 2'b01 || b_valid !== 1'b0 || d_valid !== 1'b0) begin bad++;
            $display("FAIL route_a got av=%b ad=%b bv=%b dv=%b want 1 01 0 0", a_valid, a_data, b_valid, d_valid); end
        send(2'b10, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        total++; if (b_valid !== 1'b1 || b_data !== 2'b10 || a_valid !== 1'b0 || d_valid !== 1'b0) begin bad++;
            $display("FAIL route_b got bv=%b bd=%b av=%b dv=%b want 1 10 0 0", b_valid, b_data, a_valid, d_valid); end
        send(2'b11, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        total++; if (d_valid !== 1'b1 || d_data !== 2'b11 || a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++;
            $display("FAIL route_d got dv=%b dd=%b av=%b bv=%b want 1 11 0 0", d_valid, d_data, a_valid, b_valid); end
        total++; if (busy !== 1'b1) begin bad++;
            $display("FAIL route_busy got %b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++;
            $display("FAIL route_drained_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        b_ready = 1'b0;
        send(2'b01, 1'b1, 1'b0);
        tick();
        send(2'b10, 1'b1, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL bp_ready_count1 got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++;
            $display("FAIL bp_ready_full_b got %b want 0", in_ready); end
        S = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL bp_ready_route_a got %b want 1", in_ready); end
        S = 1'b0;
        b_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0 || b_data !== 2'b01 || b_valid !== 1'b1) begin bad++;
            $display("FAIL bp_full_no_passthru got rdy=%b bd=%b bv=%b want 0 01 1", in_ready, b_data, b_valid); end
        tick();
        total++; if (b_valid !== 1'b1 || b_data !== 2'b10 || in_ready !== 1'b1) begin bad++;
            $display("FAIL bp_second_word got bv=%b bd=%b rdy=%b want 1 10 1", b_valid, b_data, in_ready); end
        tick();
        total++; if (b_valid !== 1'b0) begin bad++;
            $display("FAIL bp_drained got bv=%b want 0", b_valid); end
    endtask

    task automatic test_pushpop_d();
        d_ready = 1'b0;
        send(2'b00, 1'b0, 1'b1);
        tick();
        total++; if (d_valid !== 1'b1 || d_data !== 2'b00) begin bad++;
            $display("FAIL pp_first got dv=%b dd=%b want 1 00", d_valid, d_data); end
        d_ready = 1'b1;
        send(2'b11, 1'b0, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL pp_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        d_ready  = 1'b0;
        total++; if (d_valid !== 1'b1 || d_data !== 2'b11) begin bad++;
            $display("FAIL pp_new_head got dv=%b dd=%b want 1 11", d_valid, d_data); end
        tick();
        d_ready = 1'b1;
        tick();
        total++; if (d_valid !== 1'b0) begin bad++;
            $display("FAIL pp_count_one got dv=%b want 0", d_valid); end
    endtask

    task automatic test_random();
        logic [1:0] q [3][$];
        logic       vld [3];
        logic [1:0] dat [3];
        logic       rdy [3];
        logic       stalled;
        int         sel;
        logic       exp_rdy;
        logic       acc;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (stalled && $urandom_range(0, 3) != 0) begin
                // producer keeps the same word and route
            end else if (stalled) begin
                S1 = 1'($urandom); S = 1'($urandom);
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 2'($urandom);
                S1       = 1'($urandom);
                S        = 1'($urandom);
            end
            a_ready = ($urandom_range(0, 2) != 0);
            b_ready = ($urandom_range(0, 2) != 0);
            d_ready = ($urandom_range(0, 2) != 0);
            #1;
            sel     = !S1 ? 2 : (S ? 0 : 1);
            exp_rdy = (q[sel].size() < 2);
            vld = '{a_valid, b_valid, d_valid};
            dat = '{a_data, b_data, d_data};
            rdy = '{a_ready, b_ready, d_ready};
            total++; if (in_ready !== exp_rdy) begin bad++;
                $display("FAIL rnd_in_ready cyc=%0d got %b want %b", cyc, in_ready, exp_rdy); end
            total++; if (busy !== (vld[0] | vld[1] | vld[2])) begin bad++;
                $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy, vld[0] | vld[1] | vld[2]); end
            for (int k = 0; k < 3; k++) begin
                total++; if (vld[k] !== (q[k].size() != 0)) begin bad++;
                    $display("FAIL rnd_valid%0d cyc=%0d got %b want %b", k, cyc, vld[k], q[k].size() != 0); end
                if (q[k].size() != 0) begin
                    total++; if (dat[k] !== q[k][0]) begin bad++;
                        $display("FAIL rnd_data%0d cyc=%0d got %b want %b", k, cyc, dat[k], q[k][0]); end
                end
            end
            acc = in_valid && exp_rdy;
            for (int k = 0; k < 3; k++) begin
                if (rdy[k] && q[k].size() != 0) void'(q[k].pop_front());
            end
            if (acc) q[sel].push_back(in_data);
            stalled = in_valid && !exp_rdy;
            tick();
        end
        in_valid = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1; d_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (busy !== 1'b0) begin bad++;
            $display("FAIL rnd_final_drain got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midstream();
        a_ready = 1'b0;
        send(2'b10, 1'b1, 1'b1);
        tick();
        send(2'b01, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        total++; if (a_valid !== 1'b1 || a_data !== 2'b10 || in_ready !== 1'b0) begin bad++;
            $display("FAIL mid_pre got av=%b ad=%b rdy=%b want 1 10 0", a_valid, a_data, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (a_valid !== 1'b0 || a_data !== 2'b00 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL mid_reset got av=%b ad=%b rdy=%b busy=%b want 0 00 1 0", a_valid, a_data, in_ready, busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_routing();
        test_backpressure();
        test_pushpop_d();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
